fifo_mflux: RTL and testbench
=============================

Name: fifo_mflux

Overview:
- Shared-storage multi-flux FIFO with tagged entries; next-generation multi-flux shift-register FIFO.
- Each write carries a flux tag. Each flux consumer has its own read port and data lane, and always sees the oldest entry carrying its tag.
- A stalled flux never blocks the others: no head-of-line blocking.
- Sits between one producer and FLUX dataflow consumers.

Parameters:
- DATA_WIDTH, 8: payload width in bits.
- DEPTH, 4: number of shared entries, >=2.
- FLUX, 2: number of consumer fluxes, >=2.
- AF_THRESH, DEPTH-1: almost_full asserts when occupancy >= AF_THRESH.
- Localparams: TW = max(1, $clog2(FLUX)); CW = $clog2(DEPTH+1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- din  in  DATA_WIDTH+TW  {tag, payload}; tag occupies the MSBs.
- write  in  1  write request.
- full  out  1  no free entry.
- almost_full  out  1  occupancy >= AF_THRESH.
- err_tag  out  1  one-cycle pulse: write with tag >= FLUX was dropped.
- dout  out  FLUX*DATA_WIDTH  lane f = bits [f*DATA_WIDTH +: DATA_WIDTH], head payload of flux f.
- read  in  FLUX  per-flux pop.
- empty  out  FLUX  per-flux no-entry flag.

Behaviour:
- Storage:
  - DEPTH slots with valid bits, compacted so that valid slots are 0..count-1.
  - Slot 0 holds the oldest entry.
- Head selection: head_f is the lowest valid slot whose tag == f. This is combinational, first-word-fall-through.
- dout and empty:
  - dout lane f = payload[head_f].
  - Lane f is 0 when empty[f]=1.
  - empty[f] = no valid slot with tag f.
- Write acceptance and latency:
  - A write is accepted iff write=1, full=0 and tag < FLUX.
  - An accepted word is visible on its lane and clears its empty bit in the next cycle.
- Read rules:
  - read[f] with empty[f]=0 removes head_f at the clock edge.
  - read[f] with empty[f]=1 is ignored, with no state change.
  - Several fluxes may pop in the same cycle.
- Compaction: each surviving slot i moves down by the number of removed slots below i. Relative order is kept.
- Simultaneous write and reads: removals are applied first. The new entry lands at slot count − (number of pops).
- Full and count:
  - full = (count == DEPTH), derived from registered count.
  - A write while full is ignored even if a pop happens in the same cycle; there is no pass-through.
  - count never exceeds DEPTH and never goes below 0.
- Bad tag: a write with tag >= FLUX (only possible when FLUX is not a power of 2) is dropped, and err_tag =1 for the following cycle.
- Ordering: strict FIFO within each flux. No ordering guarantee across fluxes.
- Reset (async assert, sync-release timing is the integrator's job):
  - All valids cleared, count=0.
  - empty = all ones, full=0, almost_full=0 (1 if AF_THRESH=0), err_tag=0, dout=0.
  - Takes effect immediately, mid-operation, without a clock edge.
- No state machine beyond the count/valid state. All outputs except dout are registered or derived from registered state.

Optional Feature:
- Macro FIFO_MFLUX_OCC_EN.
- Defined: adds port `occupancy  out  FLUX*CW`. Lane f is the number of valid entries tagged f. It is registered, updates in the same cycle as empty, and resets to 0.
- Undefined: the port and its counters are absent. Functional behaviour is otherwise identical.

Decomposition:
- Package fifo_mflux_pkg holds:
  - tag_width(flux) function (max(1, clog2));
  - count_width(depth) function;
  - a compile-time assertion helper for DEPTH>=2 and FLUX>=2.
- The entry struct stays local, because it is parametrised.
- Sub-module fifo_mflux_head_sel: per-flux priority finder over valid/tag vectors. Outputs a one-hot head mask and an empty flag. It is instantiated FLUX times.

Test Plan (DATA_WIDTH=8, DEPTH=4, FLUX=2, AF_THRESH=3):
- Reset: drive rst=0 with 3 entries held → at once empty=2'b11, full=0, almost_full=0, dout=0, with no clock edge needed.
- Interleave: write {0,0x11},{1,0x22},{0,0x33} → dout lane0=0x11, lane1=0x22. Then read=2'b01 → lane0=0x33 and lane1 still 0x22.
- No HOL blocking: write {0,0xA0},{1,0xB0}, then read=2'b10 only → lane1 empty (empty=2'b10), lane0=0xA0 kept.
- Full: 4 writes → almost_full=1 after the 3rd and full=1 after the 4th. A 5th write of {1,0xFF} together with read=2'b01 → 0xFF is not stored, count becomes 3.
- Concurrent: 2 entries {0,0x01},{1,0x02}, then read=2'b11 plus write {1,0x03} in one cycle → count=1, lane1=0x03, empty=2'b01.
- Underflow: read=2'b11 with empty=2'b11 → no state change, no error flagged.

Source files
------------

// File: rtl/fifo_mflux_pkg.sv
// Shared helpers for the multi-flux FIFO: derived widths and a parameter sanity check.
package fifo_mflux_pkg;

    // Width of the flux tag carried in the MSBs of each write word.
    function automatic int tag_width(input int flux);
        return (flux <= 2) ? 1 : $clog2(flux);
    endfunction

    // Width needed to hold an occupancy value from 0 up to depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Elaboration-time check used by the top to reject degenerate configurations.
    function automatic bit params_ok(input int depth, input int flux);
        return (depth >= 2) && (flux >= 2);
    endfunction

endpackage

// File: rtl/fifo_mflux_head_sel.sv
// Head finder for one flux: marks the lowest valid slot whose tag matches FLUX_ID.
module fifo_mflux_head_sel #(
    parameter int DEPTH   = 4,
    parameter int TW      = 1,
    parameter int FLUX_ID = 0
) (
    input  logic [DEPTH-1:0]         valid,
    input  logic [DEPTH-1:0][TW-1:0] tags,
    output logic [DEPTH-1:0]         head,
    output logic                     empty
);

    localparam logic [TW-1:0] ID = TW'(FLUX_ID);

    logic found;

    // Priority scan from slot 0 (oldest) upward; first match wins.
    always_comb begin
        head  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!found && valid[i] && (tags[i] == ID)) begin
                head[i] = 1'b1;
                found   = 1'b1;
            end
        end
        empty = !found;
    end

endmodule

// File: rtl/fifo_mflux.sv
// Shared-storage multi-flux FIFO: one producer, FLUX consumers, each consumer sees
// the oldest entry carrying its tag (no head-of-line blocking between fluxes).
// Optional per-flux occupancy port enabled by defining FIFO_MFLUX_OCC_EN.
module fifo_mflux
    import fifo_mflux_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int FLUX       = 2,
    parameter int AF_THRESH  = DEPTH - 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [DATA_WIDTH+tag_width(FLUX)-1:0] din,
    input  logic                                  write,
    output logic                                  full,
    output logic                                  almost_full,
    output logic                                  err_tag,
    output logic [FLUX*DATA_WIDTH-1:0]            dout,
    input  logic [FLUX-1:0]                       read,
    output logic [FLUX-1:0]                       empty
`ifdef FIFO_MFLUX_OCC_EN
    ,
    output logic [FLUX*count_width(DEPTH)-1:0]    occupancy
`endif
);

    localparam int TW = tag_width(FLUX);
    localparam int CW = count_width(DEPTH);
    localparam int IW = $clog2(DEPTH);
    localparam logic [TW:0] FLUX_W = FLUX[TW:0];

    if (!params_ok(DEPTH, FLUX)) begin : g_bad_params
        $error("fifo_mflux: DEPTH and FLUX must both be >= 2");
    end

    typedef struct packed {
        logic [TW-1:0]         tag;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t                   mem_q [DEPTH];
    entry_t                   mem_d [DEPTH];
    logic [DEPTH-1:0]         valid_q, valid_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     err_q;

    logic [TW-1:0]            din_tag;
    logic [DATA_WIDTH-1:0]    din_data;
    logic                     tag_ok;
    logic                     accept;
    logic [DEPTH-1:0][TW-1:0] tags;
    logic [DEPTH-1:0]         head [FLUX];
    logic [FLUX-1:0]          pop_f;
    logic [DEPTH-1:0]         pop_mask;
    logic [CW-1:0]            wr_idx;

    assign din_tag     = din[DATA_WIDTH +: TW];
    assign din_data    = din[DATA_WIDTH-1:0];
    assign tag_ok      = ({1'b0, din_tag} < FLUX_W);
    assign full        = (count_q == CW'(DEPTH));
    assign almost_full = (count_q >= CW'(AF_THRESH));
    assign err_tag     = err_q;
    assign accept      = write && !full && tag_ok;

    // Expose stored tags as a packed vector for the per-flux head finders.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            tags[i] = mem_q[i].tag;
        end
    end

    for (genvar f = 0; f < FLUX; f++) begin : g_head
        fifo_mflux_head_sel #(
            .DEPTH   (DEPTH),
            .TW      (TW),
            .FLUX_ID (f)
        ) u_head_sel (
            .valid (valid_q),
            .tags  (tags),
            .head  (head[f]),
            .empty (empty[f])
        );
    end

    // Per-lane read data: payload at the flux head, zero when the flux is empty.
    always_comb begin
        dout = '0;
        for (int unsigned f = 0; f < FLUX; f++) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (head[f][i]) begin
                    dout[f*DATA_WIDTH +: DATA_WIDTH] = mem_q[i].data;
                end
            end
        end
    end

    // Next storage image: drop popped heads, pack survivors down in order, append the write.
    always_comb begin
        pop_mask = '0;
        for (int unsigned f = 0; f < FLUX; f++) begin
            pop_f[f] = read[f] && !empty[f];
            if (pop_f[f]) begin
                pop_mask = pop_mask | head[f];
            end
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_d[i] = '0;
        end
        valid_d = '0;
        wr_idx  = '0;
        // Survivors are copied to a running write index, which equals the
        // per-slot "moves down by removed slots below" rule.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && !pop_mask[i]) begin
                mem_d[wr_idx[IW-1:0]]   = mem_q[i];
                valid_d[wr_idx[IW-1:0]] = 1'b1;
                wr_idx                  = wr_idx + 1'b1;
            end
        end
        if (accept) begin
            mem_d[wr_idx[IW-1:0]]   = '{tag: din_tag, data: din_data};
            valid_d[wr_idx[IW-1:0]] = 1'b1;
            wr_idx                  = wr_idx + 1'b1;
        end
        count_d = wr_idx;
    end

    // Storage, count and bad-tag flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            valid_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            valid_q <= valid_d;
            count_q <= count_d;
            err_q   <= write && !tag_ok;
        end
    end

`ifdef FIFO_MFLUX_OCC_EN
    logic [CW-1:0] occ_q [FLUX];
    logic [CW-1:0] occ_d [FLUX];

    // Per-flux entry counts follow the same pops/pushes as the shared storage.
    always_comb begin
        for (int unsigned f = 0; f < FLUX; f++) begin
            occ_d[f] = occ_q[f] - CW'(pop_f[f]) + CW'(accept && (din_tag == TW'(f)));
            occupancy[f*CW +: CW] = occ_q[f];
        end
    end

    // Per-flux occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned f = 0; f < FLUX; f++) begin
                occ_q[f] <= '0;
            end
        end else begin
            for (int unsigned f = 0; f < FLUX; f++) begin
                occ_q[f] <= occ_d[f];
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_mflux.sv
// Self-checking bench for fifo_mflux (DATA_WIDTH=8, DEPTH=4, FLUX=2, AF_THRESH=3).
module tb_fifo_mflux;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int FLUX  = 2;
    localparam int TW    = 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 write = 1'b0;
    logic [DW+TW-1:0]     din = '0;
    logic [FLUX-1:0]      read = '0;
    logic                 full, almost_full, err_tag;
    logic [FLUX*DW-1:0]   dout;
    logic [FLUX-1:0]      empty;
`ifdef FIFO_MFLUX_OCC_EN
    logic [FLUX*3-1:0]    occupancy;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: global arrival order of {tag, payload} words.
    logic [8:0] mq[$];

    typedef struct {
        logic        w;
        logic [8:0]  d;
        logic [1:0]  r;
        logic [1:0]  e_empty;
        logic        e_full;
        logic        e_af;
        logic [15:0] e_dout;
    } vec_t;

    vec_t vt[11];

    fifo_mflux #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .FLUX       (FLUX),
        .AF_THRESH  (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .write       (write),
        .full        (full),
        .almost_full (almost_full),
        .err_tag     (err_tag),
        .dout        (dout),
        .read        (read),
        .empty       (empty)
`ifdef FIFO_MFLUX_OCC_EN
        ,
        .occupancy   (occupancy)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input logic [1:0] e_empty, input logic e_full,
                            input logic e_af, input logic [15:0] e_dout);
        chk({name, " empty"}, 32'(empty), 32'(e_empty));
        chk({name, " full"}, 32'(full), 32'(e_full));
        chk({name, " almost_full"}, 32'(almost_full), 32'(e_af));
        chk({name, " dout"}, 32'(dout), 32'(e_dout));
        chk({name, " err_tag"}, 32'(err_tag), 32'(0));
    endtask

    // Model update for one clock edge: pops first, then the write if there was room before.
    task automatic m_step(input logic w, input logic [8:0] d, input logic [1:0] r);
        bit was_full;
        was_full = (mq.size() == DEPTH);
        for (int f = 0; f < FLUX; f++) begin
            if (r[f]) begin
                for (int i = 0; i < mq.size(); i++) begin
                    if (mq[i][8] == f[0]) begin
                        mq.delete(i);
                        break;
                    end
                end
            end
        end
        if (w && !was_full) mq.push_back(d);
    endtask

    task automatic m_check(input string name);
        logic [1:0]  e;
        logic [15:0] dv;
        e  = '1;
        dv = '0;
        for (int f = 0; f < FLUX; f++) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (e[f] && mq[i][8] == f[0]) begin
                    e[f] = 1'b0;
                    dv[f*8 +: 8] = mq[i][7:0];
                end
            end
        end
        chk_outs(name, e, mq.size() == DEPTH, mq.size() >= 3, dv);
`ifdef FIFO_MFLUX_OCC_EN
        for (int f = 0; f < FLUX; f++) begin
            int n;
            n = 0;
            for (int i = 0; i < mq.size(); i++) if (mq[i][8] == f[0]) n++;
            chk({name, " occupancy"}, 32'(occupancy[f*3 +: 3]), 32'(n));
        end
`endif
    endtask

    // One clock: drive inputs, advance model, sample 1 time unit after the edge.
    task automatic cycle(input logic w, input logic [8:0] d, input logic [1:0] r);
        write = w;
        din   = d;
        read  = r;
        m_step(w, d, r);
        @(posedge clk);
        #1;
        write = 1'b0;
        read  = '0;
    endtask

    initial begin
        // Hand-computed sequence: interleave, no head-of-line blocking, underflow.
        vt[0]  = '{1'b1, 9'h011, 2'b00, 2'b10, 1'b0, 1'b0, 16'h0011};
        vt[1]  = '{1'b1, 9'h122, 2'b00, 2'b00, 1'b0, 1'b0, 16'h2211};
        vt[2]  = '{1'b1, 9'h033, 2'b00, 2'b00, 1'b0, 1'b1, 16'h2211};
        vt[3]  = '{1'b0, 9'h000, 2'b01, 2'b00, 1'b0, 1'b0, 16'h2233};
        vt[4]  = '{1'b0, 9'h000, 2'b10, 2'b10, 1'b0, 1'b0, 16'h0033};
        vt[5]  = '{1'b0, 9'h000, 2'b01, 2'b11, 1'b0, 1'b0, 16'h0000};
        vt[6]  = '{1'b1, 9'h0A0, 2'b00, 2'b10, 1'b0, 1'b0, 16'h00A0};
        vt[7]  = '{1'b1, 9'h1B0, 2'b00, 2'b00, 1'b0, 1'b0, 16'hB0A0};
        vt[8]  = '{1'b0, 9'h000, 2'b10, 2'b10, 1'b0, 1'b0, 16'h00A0};
        vt[9]  = '{1'b0, 9'h000, 2'b01, 2'b11, 1'b0, 1'b0, 16'h0000};
        vt[10] = '{1'b0, 9'h000, 2'b11, 2'b11, 1'b0, 1'b0, 16'h0000};

        // Reset state without any clock edge.
        #1;
        chk_outs("reset_initial", 2'b11, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 11; k++) begin
            cycle(vt[k].w, vt[k].d, vt[k].r);
            chk_outs($sformatf("vec%0d", k), vt[k].e_empty, vt[k].e_full, vt[k].e_af, vt[k].e_dout);
        end

        // Full: almost_full after 3rd write, full after 4th, 5th write with a pop is dropped.
        cycle(1'b1, 9'h001, 2'b00);
        cycle(1'b1, 9'h102, 2'b00);
        cycle(1'b1, 9'h003, 2'b00);
        chk_outs("full_w3", 2'b00, 1'b0, 1'b1, 16'h0201);
        cycle(1'b1, 9'h104, 2'b00);
        chk_outs("full_w4", 2'b00, 1'b1, 1'b1, 16'h0201);
        cycle(1'b1, 9'h1FF, 2'b01);
        chk_outs("full_w5_pop", 2'b00, 1'b0, 1'b1, 16'h0203);
        cycle(1'b0, 9'h000, 2'b10);
        chk_outs("full_drain1", 2'b00, 1'b0, 1'b0, 16'h0403);
        cycle(1'b0, 9'h000, 2'b10);
        chk_outs("full_no_ff", 2'b10, 1'b0, 1'b0, 16'h0003);
        cycle(1'b0, 9'h000, 2'b01);
        chk_outs("full_drained", 2'b11, 1'b0, 1'b0, 16'h0000);

        // Concurrent double pop plus write in one cycle.
        cycle(1'b1, 9'h001, 2'b00);
        cycle(1'b1, 9'h102, 2'b00);
        cycle(1'b1, 9'h103, 2'b11);
        chk_outs("concurrent", 2'b01, 1'b0, 1'b0, 16'h0300);
        cycle(1'b0, 9'h000, 2'b10);
        chk_outs("concurrent_drain", 2'b11, 1'b0, 1'b0, 16'h0000);

        // Asynchronous reset mid-operation with 3 entries held.
        cycle(1'b1, 9'h0AA, 2'b00);
        cycle(1'b1, 9'h1BB, 2'b00);
        cycle(1'b1, 9'h0CC, 2'b00);
        chk_outs("pre_reset", 2'b00, 1'b0, 1'b1, 16'hBBAA);
        #2;
        rst = 1'b0;
        #1;
        chk_outs("async_reset", 2'b11, 1'b0, 1'b0, 16'h0000);
        mq.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_outs("post_reset", 2'b11, 1'b0, 1'b0, 16'h0000);

        // Randomized traffic against the queue model.
        for (int n = 0; n < 400; n++) begin
            logic        w;
            logic [8:0]  d;
            logic [1:0]  r;
            w = ($urandom_range(0, 9) < 6);
            d = 9'($urandom);
            r = 2'($urandom);
            cycle(w, d, r);
            m_check($sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
